pe_mac_lanes: RTL and testbench

//  Multi-lane pipelined multiply-accumulate processing element, the parametrised successor of the single-lane PE.

---
 rtl/pe_mac_lanes_pkg.sv | 17 +
 rtl/pe_mac_lanes_lane.sv | 90 +++++++++
 rtl/pe_mac_lanes.sv | 102 ++++++++++
 tb/tb_pe_mac_lanes.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_mac_lanes_pkg.sv
// Shared types for the multi-lane MAC processing element: operand mode encoding
// and the per-beat control word that travels down the pipeline beside the lane data.
package pe_mac_lanes_pkg;

  typedef enum logic {
    MODE_UNSIGNED = 1'b0,
    MODE_SIGNED   = 1'b1
  } mode_e;

  typedef struct packed {
    logic  valid;
    logic  isFirst;
    logic  isLast;
    mode_e mode;
  } ctrl_t;

endpackage

// File: rtl/pe_mac_lanes_lane.sv
// One MAC lane: S2 magnitude multiply with sign fix-up, S3 accumulate with overflow
// detection and optional saturation, plus this lane's slice of the result register.
module pe_mac_lanes_lane
  import pe_mac_lanes_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 40,
  parameter bit SATURATE   = 1'b1
) (
  input  logic                  clk,
  input  logic                  clr_n,
  input  logic                  en_i,
  input  logic [DATA_WIDTH-1:0] s1A_i,
  input  logic [DATA_WIDTH-1:0] s1B_i,
  input  mode_e                 s1Mode_i,
  input  logic                  s2Valid_i,
  input  logic                  s2First_i,
  input  logic                  s2Last_i,
  input  mode_e                 s2Mode_i,
  output logic [ACC_WIDTH-1:0]  outC_o,
  output logic                  outOvf_o
);
  localparam int PW = 2 * DATA_WIDTH;

  logic                  negA, negB;
  logic [DATA_WIDTH-1:0] magA, magB;
  logic [PW-1:0]         magP, prodSigned, prod_q;

  // The multiplier core works on magnitudes; the sign is restored afterwards.
  always_comb begin
    negA       = (s1Mode_i == MODE_SIGNED) && s1A_i[DATA_WIDTH-1];
    negB       = (s1Mode_i == MODE_SIGNED) && s1B_i[DATA_WIDTH-1];
    magA       = negA ? (~s1A_i + DATA_WIDTH'(1)) : s1A_i;
    magB       = negB ? (~s1B_i + DATA_WIDTH'(1)) : s1B_i;
    magP       = PW'(magA) * PW'(magB);
    prodSigned = (negA ^ negB) ? (~magP + PW'(1)) : magP;
  end

  logic [ACC_WIDTH-1:0] pExt, satVal, acc_q, acc_d, outC_q;
  logic [ACC_WIDTH:0]   sumW;
  logic                 beatOvf, ovf_q, ovf_d, outOvf_q;

  always_comb begin
    if (s2Mode_i == MODE_SIGNED) begin
      pExt    = ACC_WIDTH'($signed(prod_q));
      sumW    = {acc_q[ACC_WIDTH-1], acc_q} + {pExt[ACC_WIDTH-1], pExt};
      beatOvf = sumW[ACC_WIDTH] ^ sumW[ACC_WIDTH-1];
      satVal  = sumW[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    end else begin
      pExt    = ACC_WIDTH'(prod_q);
      sumW    = {1'b0, acc_q} + {1'b0, pExt};
      beatOvf = sumW[ACC_WIDTH];
      satVal  = '1;
    end
    acc_d = acc_q;
    ovf_d = ovf_q;
    if (s2Valid_i) begin
      // A first beat cannot overflow because ACC_WIDTH >= 2*DATA_WIDTH.
      if (s2First_i) begin
        acc_d = pExt;
        ovf_d = 1'b0;
      end else begin
        acc_d = (beatOvf && SATURATE) ? satVal : sumW[ACC_WIDTH-1:0];
        ovf_d = ovf_q | beatOvf;
      end
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      prod_q   <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      outC_q   <= '0;
      outOvf_q <= 1'b0;
    end else if (en_i) begin
      prod_q <= prodSigned;
      acc_q  <= acc_d;
      ovf_q  <= ovf_d;
      if (s2Valid_i && s2Last_i) begin
        outC_q   <= acc_d;
        outOvf_q <= ovf_d;
      end
    end
  end

  assign outC_o   = outC_q;
  assign outOvf_o = outOvf_q;

endmodule

// File: rtl/pe_mac_lanes.sv
// Multi-lane pipelined MAC processing element: shared control pipeline, frame tracking
// and output handshake around LANES independent multiply-accumulate lanes.
module pe_mac_lanes
  import pe_mac_lanes_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int LANES      = 4,
  parameter int ACC_WIDTH  = 40,
  parameter int SATURATE   = 1
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic                        mode_signed,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic                        in_first,
  input  logic                        in_last,
  input  logic [LANES*DATA_WIDTH-1:0] in_a,
  input  logic [LANES*DATA_WIDTH-1:0] in_b,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*ACC_WIDTH-1:0]  out_c,
  output logic [LANES-1:0]            out_ovf,
  output logic                        busy
);
  logic                        en, accept, firstEff;
  mode_e                       beatMode;
  ctrl_t                       s1Ctrl_q, s1Ctrl_d, s2Ctrl_q;
  logic [LANES*DATA_WIDTH-1:0] s1A_q, s1B_q;
  logic                        frameOpen_q, frameOpen_d;
  mode_e                       frameMode_q, frameMode_d;
  logic                        outValid_q, outValid_d;

  // A beat arriving with no open frame starts one; the mode is latched on that beat.
  always_comb begin
    en          = !outValid_q || out_ready;
    accept      = in_valid && en;
    firstEff    = in_first || !frameOpen_q;
    beatMode    = firstEff ? mode_e'(mode_signed) : frameMode_q;
    frameOpen_d = frameOpen_q;
    frameMode_d = frameMode_q;
    if (accept) begin
      frameOpen_d = !in_last;
      frameMode_d = beatMode;
    end
    s1Ctrl_d = '{valid: accept, isFirst: firstEff, isLast: in_last, mode: beatMode};
    outValid_d = outValid_q;
    if (en && s2Ctrl_q.valid && s2Ctrl_q.isLast) begin
      outValid_d = 1'b1;
    end else if (out_ready) begin
      outValid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      s1Ctrl_q    <= '0;
      s2Ctrl_q    <= '0;
      s1A_q       <= '0;
      s1B_q       <= '0;
      frameOpen_q <= 1'b0;
      frameMode_q <= MODE_UNSIGNED;
      outValid_q  <= 1'b0;
    end else begin
      if (en) begin
        s1Ctrl_q <= s1Ctrl_d;
        s1A_q    <= in_a;
        s1B_q    <= in_b;
        s2Ctrl_q <= s1Ctrl_q;
      end
      frameOpen_q <= frameOpen_d;
      frameMode_q <= frameMode_d;
      outValid_q  <= outValid_d;
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : gLane
    pe_mac_lanes_lane #(
      .DATA_WIDTH(DATA_WIDTH),
      .ACC_WIDTH (ACC_WIDTH),
      .SATURATE  (SATURATE != 0)
    ) uLane (
      .clk      (clk),
      .clr_n    (clr_n),
      .en_i     (en),
      .s1A_i    (s1A_q[g*DATA_WIDTH +: DATA_WIDTH]),
      .s1B_i    (s1B_q[g*DATA_WIDTH +: DATA_WIDTH]),
      .s1Mode_i (s1Ctrl_q.mode),
      .s2Valid_i(s2Ctrl_q.valid),
      .s2First_i(s2Ctrl_q.isFirst),
      .s2Last_i (s2Ctrl_q.isLast),
      .s2Mode_i (s2Ctrl_q.mode),
      .outC_o   (out_c[g*ACC_WIDTH +: ACC_WIDTH]),
      .outOvf_o (out_ovf[g])
    );
  end

  assign in_ready  = en;
  assign out_valid = outValid_q;
  assign busy      = s1Ctrl_q.valid || s2Ctrl_q.valid || frameOpen_q;

endmodule

// File: tb/tb_pe_mac_lanes.sv
// Bench for pe_mac_lanes: three configurations (40-bit saturating, 32-bit saturating,
// 32-bit wrapping) share one stimulus stream and are checked against a frame-level model.
module tb_pe_mac_lanes;
  localparam int DW = 16;
  localparam int L  = 4;
  localparam int NC = 3;

  logic clk = 1'b0;
  logic clr_n = 1'b1;
  logic mode_signed = 1'b0, in_valid = 1'b0, in_first = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [L*DW-1:0] in_a = '0, in_b = '0;

  logic inReadyA, outValidA, busyA, inReadyB, outValidB, busyB, inReadyC, outValidC, busyC;
  logic [L*40-1:0] outCA;
  logic [L*32-1:0] outCB, outCC;
  logic [L-1:0]    ovfA, ovfB, ovfC;

  int nChecks = 0;
  int nFail   = 0;

  always #5 clk = ~clk;

  pe_mac_lanes #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(40), .SATURATE(1)) dutA (
    .clk(clk), .clr_n(clr_n), .mode_signed(mode_signed), .in_valid(in_valid), .in_ready(inReadyA),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(outValidA),
    .out_ready(out_ready), .out_c(outCA), .out_ovf(ovfA), .busy(busyA));
  pe_mac_lanes #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(32), .SATURATE(1)) dutB (
    .clk(clk), .clr_n(clr_n), .mode_signed(mode_signed), .in_valid(in_valid), .in_ready(inReadyB),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(outValidB),
    .out_ready(out_ready), .out_c(outCB), .out_ovf(ovfB), .busy(busyB));
  pe_mac_lanes #(.DATA_WIDTH(DW), .LANES(L), .ACC_WIDTH(32), .SATURATE(0)) dutC (
    .clk(clk), .clr_n(clr_n), .mode_signed(mode_signed), .in_valid(in_valid), .in_ready(inReadyC),
    .in_first(in_first), .in_last(in_last), .in_a(in_a), .in_b(in_b), .out_valid(outValidC),
    .out_ready(out_ready), .out_c(outCC), .out_ovf(ovfC), .busy(busyC));

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] maskOf(input int aw);
    return (64'd1 << aw) - 64'd1;
  endfunction

  function automatic longint prodOf(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit sgn);
    if (sgn) return longint'($signed(a)) * longint'($signed(b));
    return longint'(a) * longint'(b);
  endfunction

  function automatic logic [L*DW-1:0] lv(input int lane, input logic [DW-1:0] v);
    logic [L*DW-1:0] r;
    r = '0;
    r[lane*DW +: DW] = v;
    return r;
  endfunction

  // Frame-level model: exact integer sums with range clamping or wrapping, and a
  // two-slot delay line that moves only when the pipeline is allowed to advance.
  int     awCfg [NC] = '{40, 32, 32};
  bit     satCfg[NC] = '{1'b1, 1'b1, 1'b0};
  longint accM[NC][L], s1C[NC][L], s2C[NC][L], outCM[NC][L];
  bit     ovfM[NC][L], s1O[NC][L], s2O[NC][L], outOM[NC][L];
  bit     frameOpenM, modeM, s1Any, s2Any, s1Res, s2Res, outValidM;

  initial begin
    forever begin
      @(posedge clk or negedge clr_n);
      if (!clr_n) begin
        frameOpenM = 0; modeM = 0; s1Any = 0; s2Any = 0; s1Res = 0; s2Res = 0; outValidM = 0;
        for (int c = 0; c < NC; c++)
          for (int ln = 0; ln < L; ln++) begin
            accM[c][ln] = 0; s1C[c][ln] = 0; s2C[c][ln] = 0; outCM[c][ln] = 0;
            ovfM[c][ln] = 0; s1O[c][ln] = 0; s2O[c][ln] = 0; outOM[c][ln] = 0;
          end
      end else begin
        bit enM, acc, fEff, m;
        longint p, s, hi, lo;
        enM = !outValidM || out_ready;
        acc = in_valid && enM;
        if (acc) begin
          fEff = in_first || !frameOpenM;
          m = fEff ? mode_signed : modeM;
          modeM = m;
          for (int c = 0; c < NC; c++)
            for (int ln = 0; ln < L; ln++) begin
              p = prodOf(in_a[ln*DW +: DW], in_b[ln*DW +: DW], m);
              if (fEff) begin
                accM[c][ln] = p;
                ovfM[c][ln] = 0;
              end else begin
                s  = accM[c][ln] + p;
                hi = m ? (longint'(1) <<< (awCfg[c] - 1)) - 1 : (longint'(1) <<< awCfg[c]) - 1;
                lo = m ? -(longint'(1) <<< (awCfg[c] - 1)) : 0;
                if (s > hi || s < lo) begin
                  ovfM[c][ln] = 1;
                  if (satCfg[c]) s = (s > hi) ? hi : lo;
                  else begin
                    s = s & longint'(maskOf(awCfg[c]));
                    if (m && s[awCfg[c]-1]) s = s - (longint'(1) <<< awCfg[c]);
                  end
                end
                accM[c][ln] = s;
              end
            end
          frameOpenM = !in_last;
        end
        if (enM) begin
          if (s2Res) begin
            outValidM = 1; outCM = s2C; outOM = s2O;
          end else if (out_ready) begin
            outValidM = 0;
          end
          s2Any = s1Any; s2Res = s1Res; s2C = s1C; s2O = s1O;
          s1Any = acc; s1Res = acc && in_last;
          if (acc && in_last) begin
            s1C = accM; s1O = ovfM;
          end
        end
      end
    end
  end

  // Cycle-by-cycle comparison of every DUT output against the model.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (clr_n) begin
        bit exReady, exBusy;
        exReady = !outValidM || out_ready;
        exBusy  = s1Any || s2Any || frameOpenM;
        checkOutput("in_ready_A", 64'(inReadyA), 64'(exReady));
        checkOutput("in_ready_B", 64'(inReadyB), 64'(exReady));
        checkOutput("in_ready_C", 64'(inReadyC), 64'(exReady));
        checkOutput("out_valid_A", 64'(outValidA), 64'(outValidM));
        checkOutput("out_valid_B", 64'(outValidB), 64'(outValidM));
        checkOutput("out_valid_C", 64'(outValidC), 64'(outValidM));
        checkOutput("busy_A", 64'(busyA), 64'(exBusy));
        checkOutput("busy_B", 64'(busyB), 64'(exBusy));
        checkOutput("busy_C", 64'(busyC), 64'(exBusy));
        for (int ln = 0; ln < L; ln++) begin
          checkOutput($sformatf("out_c_A[%0d]", ln), 64'(outCA[ln*40 +: 40]), outCM[0][ln] & maskOf(40));
          checkOutput($sformatf("out_c_B[%0d]", ln), 64'(outCB[ln*32 +: 32]), outCM[1][ln] & maskOf(32));
          checkOutput($sformatf("out_c_C[%0d]", ln), 64'(outCC[ln*32 +: 32]), outCM[2][ln] & maskOf(32));
          checkOutput($sformatf("out_ovf_A[%0d]", ln), 64'(ovfA[ln]), 64'(outOM[0][ln]));
          checkOutput($sformatf("out_ovf_B[%0d]", ln), 64'(ovfB[ln]), 64'(outOM[1][ln]));
          checkOutput($sformatf("out_ovf_C[%0d]", ln), 64'(ovfC[ln]), 64'(outOM[2][ln]));
        end
      end
    end
  end

  // Presents one beat and returns on the falling edge after it has been accepted.
  task automatic applyStimulus(input bit f, input bit l, input bit s,
                               input logic [L*DW-1:0] a, input logic [L*DW-1:0] b);
    int n = 0;
    in_valid = 1'b1; in_first = f; in_last = l; mode_signed = s; in_a = a; in_b = b;
    #1;
    while (!inReadyA && n < 50) begin
      @(negedge clk); #1; n++;
    end
    if (!inReadyA) begin
      nChecks++; nFail++;
      $display("[TB] FAIL beat_accept: in_ready=0 for 50 cycles, required 1");
    end
    @(negedge clk);
  endtask

  task automatic idle();
    in_valid = 1'b0; in_first = 1'b0; in_last = 1'b0;
  endtask

  task automatic waitResult(input string tag);
    int n = 0;
    while (!outValidA && n < 20) begin
      @(negedge clk); n++;
    end
    if (!outValidA) begin
      nChecks++; nFail++;
      $display("[TB] FAIL %s_timeout: out_valid=0 after 20 cycles, required 1", tag);
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [L*DW-1:0] va, vb;
    #1 clr_n = 1'b0;
    #1;
    checkOutput("reset_in_ready", 64'(inReadyA), 64'd1);
    checkOutput("reset_out_valid", 64'(outValidA), 64'd0);
    checkOutput("reset_busy", 64'(busyA), 64'd0);
    checkOutput("reset_out_c", 64'(outCA != '0), 64'd0);
    checkOutput("reset_out_ovf", 64'(ovfA), 64'd0);
    @(negedge clk); clr_n = 1'b1;
    @(negedge clk);

    $display("[TB] unsigned 4-beat frame, lane0 3*3");
    out_ready = 1'b1;
    va = {16'd9, 16'd1000, 16'hFFFF, 16'd3};
    vb = {16'd11, 16'd2000, 16'hFFFF, 16'd3};
    applyStimulus(1, 0, 0, va, vb);
    applyStimulus(0, 0, 0, va, vb);
    applyStimulus(0, 0, 0, va, vb);
    applyStimulus(0, 1, 0, va, vb);
    idle();
    @(negedge clk);
    checkOutput("latency_k1_valid", 64'(outValidA), 64'd0);
    @(negedge clk);
    checkOutput("latency_k2_valid", 64'(outValidA), 64'd1);
    checkOutput("unsigned_lane0", 64'(outCA[39:0]), 64'd36);
    checkOutput("unsigned_lane0_ovf", 64'(ovfA[0]), 64'd0);
    @(negedge clk);

    $display("[TB] signed frame on lane1, mode change mid-frame ignored");
    applyStimulus(1, 0, 1, lv(1, 16'hFFFB), lv(1, 16'd7));
    applyStimulus(0, 1, 0, lv(1, 16'd2), lv(1, 16'hFFFD));
    idle();
    waitResult("signed");
    checkOutput("signed_lane1_A", 64'(outCA[79:40]), 64'hFF_FFFF_FFD7);
    checkOutput("signed_lane1_B", 64'(outCB[63:32]), 64'hFFFF_FFD7);
    checkOutput("signed_lane1_ovf", 64'(ovfA[1]), 64'd0);
    @(negedge clk);

    $display("[TB] unsigned overflow 0xFFFF*0xFFFF twice");
    applyStimulus(1, 0, 0, lv(0, 16'hFFFF), lv(0, 16'hFFFF));
    applyStimulus(0, 1, 0, lv(0, 16'hFFFF), lv(0, 16'hFFFF));
    idle();
    waitResult("overflow");
    checkOutput("ovf_A_value", 64'(outCA[39:0]), 64'h1_FFFC_0002);
    checkOutput("ovf_A_flag", 64'(ovfA[0]), 64'd0);
    checkOutput("sat_B_value", 64'(outCB[31:0]), 64'hFFFF_FFFF);
    checkOutput("sat_B_flag", 64'(ovfB[0]), 64'd1);
    checkOutput("wrap_C_value", 64'(outCC[31:0]), 64'hFFFC_0002);
    checkOutput("wrap_C_flag", 64'(ovfC[0]), 64'd1);
    @(negedge clk);

    $display("[TB] backpressure with two single-beat frames");
    out_ready = 1'b0;
    applyStimulus(1, 1, 0, lv(0, 16'd5), lv(0, 16'd6));
    applyStimulus(1, 1, 0, lv(0, 16'd7), lv(0, 16'd8));
    idle();
    repeat (4) @(negedge clk);
    checkOutput("bp_held_valid", 64'(outValidA), 64'd1);
    checkOutput("bp_in_ready", 64'(inReadyA), 64'd0);
    checkOutput("bp_held_first", 64'(outCA[39:0]), 64'd30);
    @(negedge clk);
    checkOutput("bp_still_first", 64'(outCA[39:0]), 64'd30);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_second_valid", 64'(outValidA), 64'd1);
    checkOutput("bp_second_value", 64'(outCA[39:0]), 64'd56);
    @(negedge clk);
    checkOutput("bp_drained", 64'(outValidA), 64'd0);
    checkOutput("bp_value_held", 64'(outCA[39:0]), 64'd56);

    $display("[TB] in_first while a frame is open");
    applyStimulus(1, 0, 0, lv(0, 16'd2), lv(0, 16'd2));
    applyStimulus(0, 0, 0, lv(0, 16'd3), lv(0, 16'd3));
    applyStimulus(1, 1, 0, lv(0, 16'd4), lv(0, 16'd4));
    idle();
    waitResult("restart");
    checkOutput("restart_value", 64'(outCA[39:0]), 64'd16);
    @(negedge clk);
    checkOutput("restart_single_result", 64'(outValidA), 64'd0);

    $display("[TB] beat without in_first when no frame is open");
    applyStimulus(0, 1, 1, lv(0, 16'hFFFF), lv(0, 16'd2));
    idle();
    waitResult("implicit_first");
    checkOutput("implicit_first_value", 64'(outCA[39:0]), 64'hFF_FFFF_FFFE);
    @(negedge clk);

    $display("[TB] asynchronous reset mid-frame with a held result");
    out_ready = 1'b0;
    applyStimulus(1, 1, 0, lv(0, 16'd9), lv(0, 16'd9));
    applyStimulus(1, 0, 0, lv(0, 16'd4), lv(0, 16'd4));
    idle();
    repeat (3) @(negedge clk);
    checkOutput("prereset_valid", 64'(outValidA), 64'd1);
    checkOutput("prereset_value", 64'(outCA[39:0]), 64'd81);
    checkOutput("prereset_busy", 64'(busyA), 64'd1);
    #2 clr_n = 1'b0;
    #1;
    checkOutput("midreset_valid", 64'(outValidA), 64'd0);
    checkOutput("midreset_out_c", 64'(outCA != '0), 64'd0);
    checkOutput("midreset_ovf", 64'(ovfA), 64'd0);
    checkOutput("midreset_busy", 64'(busyA), 64'd0);
    @(negedge clk);
    clr_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    applyStimulus(1, 1, 0, lv(0, 16'd2), lv(0, 16'd3));
    idle();
    waitResult("postreset");
    checkOutput("postreset_value", 64'(outCA[39:0]), 64'd6);
    repeat (5) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
